// File: rtl/fifo_pack_reader_pkg.sv
// fifo_pack_reader_pkg: shared types and constants for the FIFO pack reader.
// Holds the FSM state encoding, default widths and the pop-counter width.
package fifo_pack_reader_pkg;

   localparam int DEF_DATA_WIDTH  = 4;
   localparam int DEF_PACK_FACTOR = 3;
   localparam int OUT_WIDTH       = DEF_DATA_WIDTH * DEF_PACK_FACTOR;
   localparam int POPCNT_W        = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2
   } state_e;

endpackage

// File: rtl/fifo_pack_reader.sv
// fifo_pack_reader: pops PACK_FACTOR words from a show-ahead FIFO and packs
// them (lane 0 = first word, in the LSBs) into one wide valid/ready word.
// Ports: clk, rst_n (async, active low), clr (sync flush, drops partial pack),
//   fifo_dout/fifo_empty_n/fifo_deq (FIFO read side),
//   out_data/out_valid/out_ready (packed output), busy (pack in progress).
// Optional: define FIFO_PACK_READER_POPCNT_EN to add pop_count[15:0], a
//   wrapping count of popped words cleared by reset and clr.
module fifo_pack_reader
   import fifo_pack_reader_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int PACK_FACTOR   = DEF_PACK_FACTOR,
   parameter int COUNTER_WIDTH = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              clr,
   input  logic [DATA_WIDTH-1:0]             fifo_dout,
   input  logic                              fifo_empty_n,
   output logic                              fifo_deq,
   output logic [DATA_WIDTH*PACK_FACTOR-1:0] out_data,
   output logic                              out_valid,
   input  logic                              out_ready,
`ifdef FIFO_PACK_READER_POPCNT_EN
   output logic [POPCNT_W-1:0]               pop_count,
`endif
   output logic                              busy
);

   localparam int OW = DATA_WIDTH * PACK_FACTOR;
   localparam logic [COUNTER_WIDTH-1:0] LAST =
      COUNTER_WIDTH'(PACK_FACTOR - 1);

   state_e                   state_q, state_d;
   logic [COUNTER_WIDTH-1:0] lane_q, lane_d;
   logic [OW-1:0]            data_q, data_d;
   logic                     valid_q, valid_d;

   always_comb begin
      state_d  = state_q;
      lane_d   = lane_q;
      data_d   = data_q;
      valid_d  = valid_q;
      fifo_deq = 1'b0;
      unique case (state_q)
         IDLE: begin
            // One dead cycle after reset release so the FIFO's own
            // reset-release cycle never sees a pop.
            state_d = FILL;
         end
         FILL: begin
            fifo_deq = fifo_empty_n & ~clr;
            if (fifo_deq) begin
               for (int i = 0; i < PACK_FACTOR; i++) begin
                  if (lane_q == COUNTER_WIDTH'(i)) begin
                     data_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_dout;
                  end
               end
               if (lane_q == LAST) begin
                  lane_d  = '0;
                  valid_d = 1'b1;
                  state_d = HOLD;
               end else begin
                  lane_d = lane_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (valid_q && out_ready) begin
               valid_d = 1'b0;
               state_d = FILL;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Flush wins over any pop or handshake in the same cycle.
      if (clr) begin
         state_d = (state_q == IDLE) ? IDLE : FILL;
         lane_d  = '0;
         valid_d = 1'b0;
         data_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         lane_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign busy      = (state_q != IDLE) && ((lane_q != '0) || valid_q);

`ifdef FIFO_PACK_READER_POPCNT_EN
   logic [POPCNT_W-1:0] pcnt_q, pcnt_d;

   always_comb begin
      pcnt_d = pcnt_q + POPCNT_W'(fifo_deq);
      if (clr) begin
         pcnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

   assign pop_count = pcnt_q;
`endif

endmodule

// File: tb/tb_fifo_pack_reader.sv
// tb_fifo_pack_reader: cycle-by-cycle directed vectors for fifo_pack_reader
// plus hand-written sequences for paced popping and the pop counter.
module tb_fifo_pack_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic [3:0]  fifo_dout = '0;
   logic        fifo_empty_n = 1'b0;
   logic        fifo_deq;
   logic [11:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        busy;
`ifdef FIFO_PACK_READER_POPCNT_EN
   logic [15:0] pop_count;
`endif

   fifo_pack_reader #(
      .DATA_WIDTH(4),
      .PACK_FACTOR(3),
      .COUNTER_WIDTH(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .clr(clr),
      .fifo_dout(fifo_dout),
      .fifo_empty_n(fifo_empty_n),
      .fifo_deq(fifo_deq),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
`ifdef FIFO_PACK_READER_POPCNT_EN
      .pop_count(pop_count),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        clr;
      logic        en;
      logic [3:0]  din;
      logic        rdy;
      logic        deq;
      logic        val;
      logic [11:0] data;
      logic        busy;
   } vec_t;

   vec_t vq[$];
   int   total = 0;
   int   bad = 0;

   function automatic vec_t mk(logic r, logic c, logic e, logic [3:0] d,
                               logic rd, logic dq, logic v,
                               logic [11:0] dt, logic b);
      vec_t t;
      t.rst = r; t.clr = c; t.en = e; t.din = d; t.rdy = rd;
      t.deq = dq; t.val = v; t.data = dt; t.busy = b;
      return t;
   endfunction

   task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, act, exp);
      end
   endtask

   initial begin
      logic [3:0] words [3];
      int         idx;
      int         got;

      // rst clr en din rdy | deq val data busy
      // reset, release, one dead IDLE cycle
      vq.push_back(mk(0,0,1,4'h1,1, 0,0,12'h000,0));
      vq.push_back(mk(0,0,1,4'h1,1, 0,0,12'h000,0));
      vq.push_back(mk(1,0,1,4'h1,1, 0,0,12'h000,0));
      // basic pack 1,2,3
      vq.push_back(mk(1,0,1,4'h1,1, 1,0,12'h000,0));
      vq.push_back(mk(1,0,1,4'h2,1, 1,0,12'h001,1));
      vq.push_back(mk(1,0,1,4'h3,1, 1,0,12'h021,1));
      vq.push_back(mk(1,0,0,4'h0,1, 0,1,12'h321,1));
      vq.push_back(mk(1,0,0,4'h0,1, 0,0,12'h321,0));
      // backpressure: pack 1,2,3 held 4 cycles while FIFO shows 4
      vq.push_back(mk(1,0,1,4'h1,0, 1,0,12'h321,0));
      vq.push_back(mk(1,0,1,4'h2,0, 1,0,12'h321,1));
      vq.push_back(mk(1,0,1,4'h3,0, 1,0,12'h321,1));
      vq.push_back(mk(1,0,1,4'h4,0, 0,1,12'h321,1));
      vq.push_back(mk(1,0,1,4'h4,0, 0,1,12'h321,1));
      vq.push_back(mk(1,0,1,4'h4,0, 0,1,12'h321,1));
      vq.push_back(mk(1,0,1,4'h4,0, 0,1,12'h321,1));
      vq.push_back(mk(1,0,1,4'h4,1, 0,1,12'h321,1));
      vq.push_back(mk(1,0,1,4'h4,1, 1,0,12'h321,0));
      vq.push_back(mk(1,0,1,4'h5,1, 1,0,12'h324,1));
      vq.push_back(mk(1,0,1,4'h6,1, 1,0,12'h354,1));
      vq.push_back(mk(1,0,0,4'h0,1, 0,1,12'h654,1));
      // empty stall: 7, gap of 3, then 8, 9
      vq.push_back(mk(1,0,1,4'h7,1, 1,0,12'h654,0));
      vq.push_back(mk(1,0,0,4'hF,1, 0,0,12'h657,1));
      vq.push_back(mk(1,0,0,4'hF,1, 0,0,12'h657,1));
      vq.push_back(mk(1,0,0,4'hF,1, 0,0,12'h657,1));
      vq.push_back(mk(1,0,1,4'h8,1, 1,0,12'h657,1));
      vq.push_back(mk(1,0,1,4'h9,1, 1,0,12'h687,1));
      vq.push_back(mk(1,0,0,4'h0,1, 0,1,12'h987,1));
      // flush mid-pack after popping 1, 2
      vq.push_back(mk(1,0,1,4'h1,1, 1,0,12'h987,0));
      vq.push_back(mk(1,0,1,4'h2,1, 1,0,12'h981,1));
      vq.push_back(mk(1,1,1,4'hF,1, 0,0,12'h921,1));
      vq.push_back(mk(1,0,1,4'hA,1, 1,0,12'h000,0));
      vq.push_back(mk(1,0,1,4'hB,1, 1,0,12'h00A,1));
      vq.push_back(mk(1,0,1,4'hC,1, 1,0,12'h0BA,1));
      vq.push_back(mk(1,0,0,4'h0,0, 0,1,12'hCBA,1));
      // flush in HOLD with out_ready=1: word discarded
      vq.push_back(mk(1,1,1,4'h5,1, 0,1,12'hCBA,1));
      vq.push_back(mk(1,0,0,4'h0,1, 0,0,12'h000,0));
      // async reset mid-pack
      vq.push_back(mk(1,0,1,4'h3,1, 1,0,12'h000,0));
      vq.push_back(mk(0,0,1,4'h3,1, 0,0,12'h000,0));
      vq.push_back(mk(1,0,1,4'h5,1, 0,0,12'h000,0));
      vq.push_back(mk(1,0,1,4'h5,1, 1,0,12'h000,0));

      foreach (vq[i]) begin
         @(negedge clk);
         rst_n        = vq[i].rst;
         clr          = vq[i].clr;
         fifo_empty_n = vq[i].en;
         fifo_dout    = vq[i].din;
         out_ready    = vq[i].rdy;
         #1;
         chk("deq",  i, 32'(fifo_deq),  32'(vq[i].deq));
         chk("val",  i, 32'(out_valid), 32'(vq[i].val));
         chk("data", i, 32'(out_data),  32'(vq[i].data));
         chk("busy", i, 32'(busy),      32'(vq[i].busy));
      end

      // paced FIFO: words D,E,F offered every other cycle
      words[0] = 4'hD; words[1] = 4'hE; words[2] = 4'hF;
      @(negedge clk);
      rst_n = 1'b0; clr = 1'b0; fifo_empty_n = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idx = 0;
      got = 0;
      for (int c = 0; c < 30 && got == 0; c++) begin
         @(negedge clk);
         fifo_empty_n = (c % 2 == 1) && (idx < 3);
         fifo_dout    = (idx < 3) ? words[idx] : 4'h0;
         #1;
         if (out_valid) begin
            got = 1;
         end else begin
            chk("deq_gate", c, 32'(fifo_deq & ~fifo_empty_n), 32'd0);
            if (fifo_deq) idx++;
         end
      end
      chk("paced_valid", 0, 32'(got), 32'd1);
      chk("paced_data", 0, 32'(out_data), 32'hFED);

`ifdef FIFO_PACK_READER_POPCNT_EN
      @(negedge clk);
      rst_n = 1'b0; fifo_empty_n = 1'b0; out_ready = 1'b1;
      #1;
      chk("pcnt_rst", 0, 32'(pop_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      // pops on cycles 0-2, handshake on 3, pops on 4-6
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         fifo_empty_n = 1'b1;
         fifo_dout    = 4'(c);
      end
      @(negedge clk);
      fifo_empty_n = 1'b0;
      #1;
      chk("pcnt_six", 0, 32'(pop_count), 32'd6);
      @(negedge clk);
      clr = 1'b1;
      #1;
      chk("pcnt_clr_cyc", 0, 32'(pop_count), 32'd6);
      @(negedge clk);
      clr = 1'b0;
      #1;
      chk("pcnt_after", 0, 32'(pop_count), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_pack_reader.md
Name: fifo_pack_reader

Overview:
- Read-side master for the team's show-ahead `fifo`. It drives `deq` and watches `empty_n`.
- Pops PACK_FACTOR narrow words and packs them into one wide word, which it presents on a valid/ready output port.
- Sits between a feature FIFO and the downstream wide-datapath consumer in the ANN pipeline.
- Honours the FIFO's synchronous `clr` so that a flush drops any partial pack.

Parameters:
- DATA_WIDTH, 4, width of one FIFO word.
- PACK_FACTOR, 3, number of FIFO words per packed output word (minimum 2).
- COUNTER_WIDTH, 2, width of the lane counter; must satisfy 2^COUNTER_WIDTH >= PACK_FACTOR.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush; same signal that drives the FIFO's `clr`.
- fifo_dout  in  DATA_WIDTH  FIFO head word; valid whenever fifo_empty_n=1.
- fifo_empty_n  in  1  FIFO non-empty flag.
- fifo_deq  out  1  pop request; the FIFO pops on the rising edge while this is 1.
- out_data  out  DATA_WIDTH*PACK_FACTOR  packed word; lane 0 (LSBs) holds the first word popped.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  high when the state is not IDLE and lane_cnt != 0 or out_valid=1.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, lane_cnt=0, out_data=0, out_valid=0, fifo_deq=0, busy=0.
- States and transitions:
  - IDLE: fifo_deq=0. Moves to FILL unconditionally on the first rising edge after rst_n deasserts. This guarantees no pop during the FIFO's own reset-release cycle.
  - FILL: fifo_deq = fifo_empty_n & ~clr (combinational).
    - On each edge with fifo_deq=1: out_data lane[lane_cnt] <= fifo_dout and lane_cnt++.
    - If lane_cnt==PACK_FACTOR-1 at that edge: lane_cnt <= 0, out_valid <= 1, state <= HOLD.
    - If fifo_empty_n=0: wait, holding all state.
  - HOLD: fifo_deq=0 and out_data is stable.
    - On an edge with out_valid & out_ready: out_valid <= 0, state <= FILL.
    - Otherwise hold indefinitely (backpressure).
- Latency and throughput:
  - The first word is popped in the same cycle it is visible at the FIFO head.
  - out_valid rises one cycle after the PACK_FACTOR-th pop.
  - Best-case throughput is one packed word per PACK_FACTOR+1 cycles. There is no pop in the handshake cycle.
- Lane counter:
  - lane_cnt counts 0..PACK_FACTOR-1 and never exceeds PACK_FACTOR-1.
  - Unused lanes of a partial pack keep their stale values until they are overwritten.
- clr (priority over every other event except reset):
  - Forces fifo_deq=0 combinationally in that cycle.
  - Next edge: state=FILL (or stays IDLE if currently IDLE), lane_cnt=0, out_valid=0, out_data=0.
  - A word pending in HOLD is discarded even if out_ready=1 in the same cycle.
- FIFO empties mid-pack: stall in FILL with the partial lanes retained. There is no timeout.
- Reset mid-pack: all partial data is lost and the block returns to IDLE.
- The block never pops when fifo_empty_n=0. fifo_deq is purely a function of state, fifo_empty_n and clr.

Optional Feature:
- Macro: FIFO_PACK_READER_POPCNT_EN.
- When defined:
  - Adds output pop_count [15:0], which counts every word popped (each edge with fifo_deq=1).
  - The count wraps modulo 2^16.
  - It resets to 0 on rst_n and on clr.
- When undefined: the port and counter are absent, with no other behavioural change.

Decomposition:
- Package fifo_pack_reader_pkg:
  - State typedef (IDLE, FILL, HOLD, 2-bit encoding).
  - Localparam OUT_WIDTH = DATA_WIDTH*PACK_FACTOR.
  - Pop-counter width constant (16).
- No sub-module is needed. Lane register, counter and FSM stay in one module.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 for 2 cycles with fifo_empty_n=1.
  - Required: fifo_deq=0 throughout and for the first cycle after release; out_valid=0, out_data=0; fifo_deq=1 in the second cycle after release.
- Basic pack (DATA_WIDTH=4, PACK_FACTOR=3):
  - Stimulus: FIFO model supplies 1, 2, 3 back-to-back; out_ready=1.
  - Required: three consecutive fifo_deq pulses; out_valid=1 one cycle later with out_data=12'h321; out_valid drops the next cycle.
- Backpressure:
  - Stimulus: same as the basic pack, but out_ready=0 for 4 cycles, with FIFO holding words 4, 5, 6.
  - Required: out_data stays 12'h321 and fifo_deq=0 while stalled; after out_ready=1, the next pack is 12'h654.
- Empty stall:
  - Stimulus: supply 7, then drop fifo_empty_n for 3 cycles, then supply 8, 9.
  - Required: fifo_deq=0 during the gap; out_data=12'h987; busy=1 throughout the gap.
- Flush:
  - Stimulus: pop 1 and 2, then assert clr for 1 cycle, then supply A, B, C.
  - Required: fifo_deq=0 in the clr cycle; output is 12'hCBA, with no trace of 1 or 2.
  - A second case asserts clr while in HOLD: out_valid drops and no handshake occurs.
- Optional pop counter (with FIFO_PACK_READER_POPCNT_EN defined):
  - Stimulus: pop 6 words, then assert clr.
  - Required: pop_count reads 6 before clr and 0 after.
